bsr_chain_ctrl: RTL

- Parametrised boundary-scan register with its own sequencing controller.
- Wraps the primary inputs and outputs of a core and replaces the hand-instantiated per-pin boundary_cell chain used by the current scan wrappers.
- One start pulse runs a complete capture -> shift -> update sequence.
- Supports SAMPLE, EXTEST, INTEST and BYPASS modes, and a shift stall for a slow tester.

---
 rtl/bsr_chain_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/bsr_chain_ctrl.sv
// Boundary-scan register wrapping core I/O, with a built-in controller that runs
// one capture -> shift -> update sequence per start pulse.
module bsr_chain_ctrl #(
    parameter int N_IN  = 36,
    parameter int N_OUT = 39
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic [N_IN-1:0]  pin_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pin_out,
    input  logic             tdi,
    output logic             tdo,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             shift_en,
    output logic             busy,
    output logic             done
);
    localparam int L  = N_IN + N_OUT;
    localparam int CW = $clog2(L + 1);

    localparam logic [1:0] M_SAMPLE = 2'b00;
    localparam logic [1:0] M_EXTEST = 2'b01;
    localparam logic [1:0] M_INTEST = 2'b10;
    localparam logic [1:0] M_BYPASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_mode;
    logic [L-1:0]    r_shift;
    logic [L-1:0]    r_upd;
    logic            r_byp;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;

    logic            w_bypass;
    logic            w_last;

    assign w_bypass = (r_mode == M_BYPASS);
    // True on the advancing cycle whose increment makes the count hit its target.
    assign w_last   = w_bypass ? (r_cnt == CW'(0)) : (r_cnt == CW'(L - 1));

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_mode  <= M_SAMPLE;
            r_shift <= '0;
            r_upd   <= '0;
            r_byp   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mode  <= mode;
                        r_busy  <= 1'b1;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_bypass) r_byp   <= 1'b0;
                    else          r_shift <= {core_out, pin_in};
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        if (w_bypass) r_byp   <= tdi;
                        else          r_shift <= {r_shift[L-2:0], tdi};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!w_bypass) r_upd <= r_shift;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Update values stay driven after DONE because r_mode and r_upd persist.
    assign core_in = (r_mode == M_INTEST) ? r_upd[N_IN-1:0] : pin_in;
    assign pin_out = (r_mode == M_EXTEST) ? r_upd[L-1:N_IN] : core_out;
    assign tdo     = w_bypass ? r_byp : r_shift[L-1];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
